alarm_ctrl_multi: RTL and testbench



---
 rtl/alarm_pkg.sv | 33 +++
 rtl/alarm_sec_tick.sv | 34 +++
 rtl/alarm_ctrl_multi.sv | 205 ++++++++++++++++++++
 tb/tb_alarm_ctrl_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel alarm controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package alarm_pkg;

    // One-hot controller states
    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        RING   = 3'b010,
        SNOOZE = 3'b100
    } state_t;

    // Ceiling log2; returns 0 for values <= 1, so callers apply their own floor of 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Index of the lowest set bit, 0 when nothing is set (callers qualify with |v)
    function automatic logic [2:0] lsb_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alarm_sec_tick.sv
// One-second timebase: prescaler 0..CLK_HZ-1 with sync clear, tick on the last count.
// Latency: sec_tick/on_half are combinational from the prescaler register; clr takes effect next edge.
// Backpressure: none; free-running, restarts whenever clr is high.
// Ports: sys_clk, rst_n (async active-low), clr (sync restart) -> sec_tick, on_half (first half of second).
module alarm_sec_tick
    import alarm_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clr,
    output logic sec_tick,
    output logic on_half
);

    localparam int PW = (CLK_HZ > 1) ? clog2(CLK_HZ) : 1;

    logic [PW-1:0] presc;

    assign sec_tick = (presc == PW'(CLK_HZ - 1));
    assign on_half  = (presc < PW'(CLK_HZ / 2));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr || sec_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/alarm_ctrl_multi.sv
// N-channel alarm controller: edge-detects time matches, queues them, serves one at a time with ring/snooze/cancel.
// Latency: cur_time match at edge t -> pending at t+1 -> ringing at t+2 -> beep_out at t+3.
// Backpressure: none; extra triggers accumulate in pending, keys are single-cycle pulses gated by key_allow.
// Ports: sys_clk, rst_n; cur_time, alarm_time (packed per channel), alarm_en, key_allow/key_cancel/key_snooze
//        -> beep_out, ringing, snoozed, ring_id, pending.
// Build option: define ALARM_TONE_EN to modulate the on-half of beep_out with a TONE_HZ square wave.
module alarm_ctrl_multi
    import alarm_pkg::*;
#(
    parameter int N_ALARM    = 4,
    parameter int TIME_W     = 32,
    parameter int CLK_HZ     = 50000000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int TONE_HZ    = 2000,
    localparam int RID_W     = (N_ALARM > 1) ? clog2(N_ALARM) : 1
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic [TIME_W-1:0]         cur_time,
    input  logic [N_ALARM*TIME_W-1:0] alarm_time,
    input  logic [N_ALARM-1:0]        alarm_en,
    input  logic                      key_allow,
    input  logic                      key_cancel,
    input  logic                      key_snooze,
    output logic                      beep_out,
    output logic                      ringing,
    output logic                      snoozed,
    output logic [RID_W-1:0]          ring_id,
    output logic [N_ALARM-1:0]        pending
);

    localparam int MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int SEC_W   = (MAX_SEC > 1) ? clog2(MAX_SEC) : 1;
    localparam int SNZ_W   = (MAX_SNOOZE > 0) ? clog2(MAX_SNOOZE + 1) : 1;

    state_t              state;
    logic [N_ALARM-1:0]  match;
    logic [N_ALARM-1:0]  match_d;
    logic [N_ALARM-1:0]  trigger;
    logic [N_ALARM-1:0]  accept;
    logic [2:0]          next_idx;
    logic [SEC_W-1:0]    sec_cnt;
    logic [SNZ_W-1:0]    snooze_cnt;
    logic                sec_tick;
    logic                on_half;
    logic                cancel_req;
    logic                snooze_req;
    logic                en_drop;
    logic                ring_to;
    logic                snz_to;
    logic                state_chg;
    logic                ring_hold;
    logic                beep_nxt;

    // ---------------- match detection and pending queue ----------------
    always_comb begin
        match = '0;
        for (int i = 0; i < N_ALARM; i++) begin
            match[i] = alarm_en[i] && (cur_time == alarm_time[i*TIME_W +: TIME_W]);
        end
    end

    // Rising edge only: an equality held for a whole second fires once
    assign trigger  = match & ~match_d;
    assign next_idx = lsb_index(8'(pending));
    assign accept   = (state == IDLE && |pending) ? (N_ALARM'(1) << next_idx) : '0;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            match_d <= '0;
            pending <= '0;
        end else begin
            match_d <= match;
            // Acceptance and disable both beat a same-cycle trigger
            pending <= (pending | trigger) & ~accept & alarm_en;
        end
    end

    // ---------------- transition conditions ----------------
    assign cancel_req = key_allow && key_cancel;
    assign snooze_req = key_allow && key_snooze && (snooze_cnt < SNZ_W'(MAX_SNOOZE));
    assign en_drop    = !alarm_en[ring_id];
    assign ring_to    = sec_tick && (sec_cnt == SEC_W'(RING_SEC - 1));
    assign snz_to     = sec_tick && (sec_cnt == SEC_W'(SNOOZE_SEC - 1));

    always_comb begin
        state_chg = 1'b0;
        case (state)
            IDLE:    state_chg = |pending;
            RING:    state_chg = ring_to || cancel_req || en_drop || snooze_req;
            SNOOZE:  state_chg = snz_to || cancel_req || en_drop;
            default: state_chg = 1'b1;
        endcase
    end

    // Timebase restarts on every state change so each window starts on a whole second
    alarm_sec_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .clr      (state_chg),
        .sec_tick (sec_tick),
        .on_half  (on_half)
    );

    // ---------------- controller FSM ----------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ring_id    <= '0;
            snooze_cnt <= '0;
            sec_cnt    <= '0;
            ringing    <= 1'b0;
            snoozed    <= 1'b0;
        end else begin
            if (state_chg || state == IDLE) begin
                sec_cnt <= '0;
            end else if (sec_tick) begin
                sec_cnt <= sec_cnt + SEC_W'(1);
            end

            case (state)
                IDLE: begin
                    if (|pending) begin
                        state      <= RING;
                        ring_id    <= RID_W'(next_idx);
                        snooze_cnt <= '0;
                        ringing    <= 1'b1;
                    end
                end
                RING: begin
                    // Cancel has priority over a same-cycle snooze
                    if (cancel_req || en_drop || ring_to) begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                    end else if (snooze_req) begin
                        state      <= SNOOZE;
                        snooze_cnt <= snooze_cnt + SNZ_W'(1);
                        ringing    <= 1'b0;
                        snoozed    <= 1'b1;
                    end
                end
                SNOOZE: begin
                    if (cancel_req || en_drop) begin
                        state   <= IDLE;
                        snoozed <= 1'b0;
                    end else if (snz_to) begin
                        state   <= RING;
                        ringing <= 1'b1;
                        snoozed <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ringing <= 1'b0;
                    snoozed <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- buzzer drive ----------------
    // Only sound while staying in RING, so beep_out drops on the same edge the FSM leaves
    assign ring_hold = (state == RING) && !state_chg;

`ifdef ALARM_TONE_EN
    localparam int TONE_DIV = (CLK_HZ / (2 * TONE_HZ) > 1) ? CLK_HZ / (2 * TONE_HZ) : 1;
    localparam int TW       = (TONE_DIV > 1) ? clog2(TONE_DIV) : 1;

    logic [TW-1:0] tone_cnt;
    logic          tone_lvl;

    // Held in reset outside the on-half so every on-half starts on a high tone phase
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            tone_lvl <= 1'b1;
        end else if (!(ring_hold && on_half)) begin
            tone_cnt <= '0;
            tone_lvl <= 1'b1;
        end else if (tone_cnt == TW'(TONE_DIV - 1)) begin
            tone_cnt <= '0;
            tone_lvl <= ~tone_lvl;
        end else begin
            tone_cnt <= tone_cnt + TW'(1);
        end
    end

    assign beep_nxt = ring_hold && on_half && tone_lvl;
`else
    assign beep_nxt = ring_hold && on_half;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_out <= 1'b0;
        end else begin
            beep_out <= beep_nxt;
        end
    end

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Self-checking bench for alarm_ctrl_multi with CLK_HZ=10, RING_SEC=4, SNOOZE_SEC=2, N_ALARM=4.
// Inputs driven and outputs sampled on the falling edge; a monitor pops expected ring ids per new ring event.
module tb_alarm_ctrl_multi;

    localparam logic [31:0] NEUTRAL = 32'h0000_0001;

    logic         sys_clk;
    logic         rst_n;
    logic [31:0]  cur_time;
    logic [127:0] alarm_time;
    logic [3:0]   alarm_en;
    logic         key_allow;
    logic         key_cancel;
    logic         key_snooze;
    logic         beep_out;
    logic         ringing;
    logic         snoozed;
    logic [1:0]   ring_id;
    logic [3:0]   pending;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [1:0]   exp_q[$];
    logic [1:0]   exp_id;
    logic         prev_r = 1'b0;
    logic         prev_s = 1'b0;

    alarm_ctrl_multi #(
        .N_ALARM    (4),
        .TIME_W     (32),
        .CLK_HZ     (10),
        .RING_SEC   (4),
        .SNOOZE_SEC (2),
        .MAX_SNOOZE (3),
        .TONE_HZ    (2)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .cur_time   (cur_time),
        .alarm_time (alarm_time),
        .alarm_en   (alarm_en),
        .key_allow  (key_allow),
        .key_cancel (key_cancel),
        .key_snooze (key_snooze),
        .beep_out   (beep_out),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .ring_id    (ring_id),
        .pending    (pending)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want end before 200000 time units");
        $fatal(1, "watchdog timeout");
    end

    // Scoreboard: every ring event entered from IDLE must match the next expected channel
    initial begin
        forever begin
            @(negedge sys_clk);
            if (ringing === 1'b1 && !prev_r && !prev_s) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_ring: got ring on id %0d, want no ring", ring_id);
                end else begin
                    exp_id = exp_q.pop_front();
                    if (ring_id !== exp_id) begin
                        n_fail++;
                        $display("FAIL sb_ring_id: got %0d want %0d", ring_id, exp_id);
                    end
                end
            end
            prev_r = ringing;
            prev_s = snoozed;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_alarm(input int ch, input logic [31:0] t);
        alarm_time[ch*32 +: 32] = t;
    endtask

    task automatic test_reset();
        cyc(2);
        n_chk++; if ({beep_out, ringing, snoozed} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {beep_out, ringing, snoozed}); end
        n_chk++; if (ring_id !== 2'd0) begin n_fail++; $display("FAIL rst_ring_id: got %0d want 0", ring_id); end
        n_chk++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL rst_pending: got %b want 0000", pending); end
        rst_n = 1'b1;
        cyc(3);
        n_chk++; if ({beep_out, ringing, snoozed, pending} !== 7'd0) begin n_fail++; $display("FAIL rst_idle: got %b want 0", {beep_out, ringing, snoozed, pending}); end
    endtask

    task automatic test_single_latency();
        cur_time = NEUTRAL; alarm_time = '0; set_alarm(1, 32'h0007_0000); alarm_en = 4'b0010;
        cyc(2);
        cur_time = 32'h0007_0000; exp_q.push_back(2'd1);
        cyc(1);
        n_chk++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL t1_pending: got %b want 0010", pending); end
        n_chk++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL t1_ringing_early: got %b want 0", ringing); end
        cyc(1);
        n_chk++; if (ringing !== 1'b1 || ring_id !== 2'd1) begin n_fail++; $display("FAIL t1_ring: got ringing=%b id=%0d want 1/1", ringing, ring_id); end
        n_chk++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL t1_pending_accept: got %b want 0000", pending); end
        n_chk++; if (beep_out !== 1'b0) begin n_fail++; $display("FAIL t1_beep_early: got %b want 0", beep_out); end
        cyc(1);
        n_chk++; if (beep_out !== 1'b1) begin n_fail++; $display("FAIL t1_beep_on: got %b want 1", beep_out); end
        cyc(4);
        n_chk++; if (beep_out !== 1'b1) begin n_fail++; $display("FAIL t1_beep_on_end: got %b want 1", beep_out); end
        cyc(1);
        n_chk++; if (beep_out !== 1'b0) begin n_fail++; $display("FAIL t1_beep_off: got %b want 0", beep_out); end
        cyc(33);
        n_chk++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL t1_ring_last: got %b want 1", ringing); end
        cyc(1);
        n_chk++; if (ringing !== 1'b0 || beep_out !== 1'b0) begin n_fail++; $display("FAIL t1_timeout: got ringing=%b beep=%b want 0/0", ringing, beep_out); end
        cur_time = NEUTRAL;
    endtask

    task automatic test_held_equality();
        cur_time = NEUTRAL; alarm_time = '0; set_alarm(1, 32'h0008_0000); alarm_en = 4'b0010;
        cyc(2);
        cur_time = 32'h0008_0000; exp_q.push_back(2'd1);
        cyc(2);
        n_chk++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL t2_ring: got %b want 1", ringing); end
        cyc(28);
        n_chk++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL t2_no_retrigger: got %b want 0000", pending); end
        cur_time = NEUTRAL;
        cyc(12);
        n_chk++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL t2_timeout: got %b want 0", ringing); end
        cyc(10);
        n_chk++; if (ringing !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL t2_no_rering: got ringing=%b pending=%b want 0/0000", ringing, pending); end
    endtask

    task automatic test_simultaneous();
        cur_time = NEUTRAL; alarm_time = '0;
        set_alarm(0, 32'h0009_0000); set_alarm(1, 32'h0009_0100); set_alarm(2, 32'h0009_0000);
        alarm_en = 4'b0101;
        cyc(2);
        cur_time = 32'h0009_0000; exp_q.push_back(2'd0); exp_q.push_back(2'd2);
        cyc(1);
        n_chk++; if (pending !== 4'b0101) begin n_fail++; $display("FAIL t3_pending_both: got %b want 0101", pending); end
        cyc(1);
        n_chk++; if (ringing !== 1'b1 || ring_id !== 2'd0) begin n_fail++; $display("FAIL t3_first: got ringing=%b id=%0d want 1/0", ringing, ring_id); end
        n_chk++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL t3_pending_rest: got %b want 0100", pending); end
        cyc(40);
        n_chk++; if (ringing !== 1'b0 || pending !== 4'b0100) begin n_fail++; $display("FAIL t3_gap: got ringing=%b pending=%b want 0/0100", ringing, pending); end
        cyc(1);
        n_chk++; if (ringing !== 1'b1 || ring_id !== 2'd2 || pending !== 4'b0000) begin n_fail++; $display("FAIL t3_second: got ringing=%b id=%0d pending=%b want 1/2/0000", ringing, ring_id, pending); end
        cur_time = NEUTRAL; key_cancel = 1'b1;
        cyc(1);
        key_cancel = 1'b0;
        n_chk++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL t3_cancel: got %b want 0", ringing); end
    endtask

    task automatic test_snooze();
        cur_time = NEUTRAL; alarm_time = '0; set_alarm(3, 32'h000A_0000); alarm_en = 4'b1000;
        cyc(2);
        cur_time = 32'h000A_0000; exp_q.push_back(2'd3);
        cyc(2);
        n_chk++; if (ringing !== 1'b1 || ring_id !== 2'd3) begin n_fail++; $display("FAIL t4_ring: got ringing=%b id=%0d want 1/3", ringing, ring_id); end
        for (int k = 1; k <= 3; k++) begin
            key_snooze = 1'b1;
            cyc(1);
            key_snooze = 1'b0;
            n_chk++; if (snoozed !== 1'b1 || ringing !== 1'b0 || beep_out !== 1'b0) begin n_fail++; $display("FAIL t4_enter_%0d: got snoozed=%b ringing=%b beep=%b want 1/0/0", k, snoozed, ringing, beep_out); end
            for (int i = 1; i <= 19; i++) begin
                cyc(1);
                n_chk++; if (snoozed !== 1'b1 || beep_out !== 1'b0) begin n_fail++; $display("FAIL t4_hold_%0d_%0d: got snoozed=%b beep=%b want 1/0", k, i, snoozed, beep_out); end
            end
            cyc(1);
            n_chk++; if (ringing !== 1'b1 || snoozed !== 1'b0 || ring_id !== 2'd3) begin n_fail++; $display("FAIL t4_return_%0d: got ringing=%b snoozed=%b id=%0d want 1/0/3", k, ringing, snoozed, ring_id); end
        end
        key_snooze = 1'b1;
        cyc(1);
        key_snooze = 1'b0;
        n_chk++; if (ringing !== 1'b1 || snoozed !== 1'b0) begin n_fail++; $display("FAIL t4_limit: got ringing=%b snoozed=%b want 1/0", ringing, snoozed); end
        key_cancel = 1'b1;
        cyc(1);
        key_cancel = 1'b0; cur_time = NEUTRAL;
        n_chk++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL t4_cancel: got %b want 0", ringing); end
    endtask

    task automatic test_cancel_gating();
        cur_time = NEUTRAL; alarm_time = '0; set_alarm(0, 32'h000B_0000); alarm_en = 4'b0001;
        cyc(2);
        cur_time = 32'h000B_0000; exp_q.push_back(2'd0);
        cyc(2);
        key_allow = 1'b0; key_cancel = 1'b1;
        cyc(1);
        key_cancel = 1'b0;
        n_chk++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL t5_gated_cancel: got %b want 1", ringing); end
        key_snooze = 1'b1;
        cyc(1);
        key_snooze = 1'b0; key_allow = 1'b1;
        n_chk++; if (ringing !== 1'b1 || snoozed !== 1'b0) begin n_fail++; $display("FAIL t5_gated_snooze: got ringing=%b snoozed=%b want 1/0", ringing, snoozed); end
        key_cancel = 1'b1;
        cyc(1);
        key_cancel = 1'b0;
        n_chk++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL t5_cancel: got %b want 0", ringing); end
        cur_time = NEUTRAL; set_alarm(0, 32'h000C_0000);
        cyc(2);
        cur_time = 32'h000C_0000; exp_q.push_back(2'd0);
        cyc(2);
        n_chk++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL t5_ring2: got %b want 1", ringing); end
        key_cancel = 1'b1; key_snooze = 1'b1;
        cyc(1);
        key_cancel = 1'b0; key_snooze = 1'b0; cur_time = NEUTRAL;
        n_chk++; if (ringing !== 1'b0 || snoozed !== 1'b0) begin n_fail++; $display("FAIL t5_cancel_wins: got ringing=%b snoozed=%b want 0/0", ringing, snoozed); end
    endtask

    task automatic test_disable_and_reset();
        cur_time = NEUTRAL; alarm_time = '0;
        set_alarm(2, 32'h000D_0000); set_alarm(3, 32'h000F_0000); alarm_en = 4'b0100;
        cyc(2);
        cur_time = 32'h000D_0000; exp_q.push_back(2'd2);
        cyc(2);
        n_chk++; if (ringing !== 1'b1 || ring_id !== 2'd2) begin n_fail++; $display("FAIL t6_ring: got ringing=%b id=%0d want 1/2", ringing, ring_id); end
        cur_time = NEUTRAL;
        cyc(1);
        cur_time = 32'h000D_0000;
        cyc(1);
        n_chk++; if (pending !== 4'b0100 || ringing !== 1'b1) begin n_fail++; $display("FAIL t6_retrigger: got pending=%b ringing=%b want 0100/1", pending, ringing); end
        cur_time = NEUTRAL; alarm_en = 4'b0000;
        cyc(1);
        n_chk++; if (ringing !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL t6_disable: got ringing=%b pending=%b want 0/0000", ringing, pending); end
        alarm_en = 4'b0100;
        cyc(3);
        n_chk++; if (ringing !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL t6_reenable: got ringing=%b pending=%b want 0/0000", ringing, pending); end
        set_alarm(2, 32'h000E_0000);
        cyc(1);
        cur_time = 32'h000E_0000; exp_q.push_back(2'd2);
        cyc(2);
        n_chk++; if (ringing !== 1'b1 || ring_id !== 2'd2) begin n_fail++; $display("FAIL t6_ring2: got ringing=%b id=%0d want 1/2", ringing, ring_id); end
        key_snooze = 1'b1;
        cyc(1);
        key_snooze = 1'b0; alarm_en = 4'b1100; cur_time = 32'h000F_0000;
        cyc(2);
        n_chk++; if (snoozed !== 1'b1 || pending !== 4'b1000) begin n_fail++; $display("FAIL t6_snooze_pending: got snoozed=%b pending=%b want 1/1000", snoozed, pending); end
        cyc(3);
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({beep_out, ringing, snoozed} !== 3'b000 || ring_id !== 2'd0 || pending !== 4'b0000) begin n_fail++; $display("FAIL t6_async_reset: got flags=%b id=%0d pending=%b want 000/0/0000", {beep_out, ringing, snoozed}, ring_id, pending); end
        alarm_en = 4'b0000; cur_time = NEUTRAL;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        n_chk++; if (ringing !== 1'b0 || snoozed !== 1'b0) begin n_fail++; $display("FAIL t6_after_reset: got ringing=%b snoozed=%b want 0/0", ringing, snoozed); end
    endtask

    initial begin
        rst_n      = 1'b0;
        cur_time   = NEUTRAL;
        alarm_time = '0;
        alarm_en   = '0;
        key_allow  = 1'b1;
        key_cancel = 1'b0;
        key_snooze = 1'b0;

        test_reset();
        test_single_latency();
        test_held_equality();
        test_simultaneous();
        test_snooze();
        test_cancel_gating();
        test_disable_and_reset();

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d unserved expected rings, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
